// File: rtl/db_pkg.sv
// Shared constants and width helpers for the multi-channel switch debouncer.
package db_pkg;

   localparam int DEF_CH          = 4;
   localparam int DEF_TICK_DIV    = 500000;  // 5 ms sample period on a 100 MHz board clock
   localparam int DEF_STABLE      = 3;
   localparam int DEF_SYNC_STAGES = 2;

   function automatic int clog2_f(input int value);
      int result;
      int v;
      result = 32'sd0;
      v      = value - 32'sd1;
      while (v > 32'sd0) begin
         result = result + 32'sd1;
         v      = v >>> 1;
      end
      return result;
   endfunction

   // Register width for a counter; never narrower than one bit.
   function automatic int width_f(input int value);
      return (clog2_f(value) < 32'sd1) ? 32'sd1 : clog2_f(value);
   endfunction

endpackage

// File: rtl/db_channel.sv
// One debounce channel: input synchroniser, stable-tick counter, debounced
// level and registered rise/fall pulses.
module db_channel
   import db_pkg::*;
#(
   parameter int STABLE      = DEF_STABLE,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sw_i,
   input  logic tick,
   output logic db,
   output logic rise,
   output logic fall
);

   localparam int            CW       = width_f(STABLE + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 32'sd1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   s_s;
   logic [CW-1:0]          cnt_r;
   logic [CW-1:0]          cnt_nxt_s;
   logic                   db_r;
   logic                   db_nxt_s;
   logic                   rise_r;
   logic                   rise_nxt_s;
   logic                   fall_r;
   logic                   fall_nxt_s;

   assign s_s = sync_r[SYNC_STAGES-1];

   // Synchroniser chain for the asynchronous switch input
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], sw_i};
      end
   end

   // Next-state: count ticks while the input disagrees, flip after STABLE of them
   always_comb begin
      cnt_nxt_s  = cnt_r;
      db_nxt_s   = db_r;
      rise_nxt_s = 1'b0;
      fall_nxt_s = 1'b0;
      if (s_s == db_r) begin
         cnt_nxt_s = {CW{1'b0}};
      end else if (tick) begin
         if (cnt_r == CNT_LAST) begin
            db_nxt_s   = ~db_r;
            cnt_nxt_s  = {CW{1'b0}};
            rise_nxt_s = ~db_r;
            fall_nxt_s = db_r;
         end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
         end
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Channel state and edge pulse registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r  <= {CW{1'b0}};
         db_r   <= 1'b0;
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_nxt_s;
         db_r   <= db_nxt_s;
         rise_r <= rise_nxt_s;
         fall_r <= fall_nxt_s;
      end
   end

   assign db   = db_r;
   assign rise = rise_r;
   assign fall = fall_r;

endmodule

// File: rtl/db_multi.sv
// Multi-channel switch debouncer: one shared sample-tick prescaler driving
// CH independent debounce channels.
module db_multi
   import db_pkg::*;
#(
   parameter int CH          = DEF_CH,
   parameter int TICK_DIV    = DEF_TICK_DIV,
   parameter int STABLE      = DEF_STABLE,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [CH-1:0] sw,
   output logic [CH-1:0] db,
   output logic [CH-1:0] rise,
   output logic [CH-1:0] fall,
   output logic          tick
);

   localparam int            PW       = width_f(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 32'sd1);
   localparam logic [PW-1:0] PRE_ONE  = PW'(32'd1);

   logic [PW-1:0] pre_r;
   logic          tick_s;

   // With TICK_DIV=1 the counter sits at 0 == PRE_LAST, so tick is always high.
   assign tick_s = (pre_r == PRE_LAST);
   assign tick   = tick_s;

   // Sample-tick prescaler, wraps at TICK_DIV-1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_r <= {PW{1'b0}};
      end else if (tick_s) begin
         pre_r <= {PW{1'b0}};
      end else begin
         pre_r <= pre_r + PRE_ONE;
      end
   end

   for (genvar g = 0; g < CH; g++) begin : g_ch
      db_channel #(
         .STABLE      (STABLE),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .clk     (clk),
         .reset_n (reset_n),
         .sw_i    (sw[g]),
         .tick    (tick_s),
         .db      (db[g]),
         .rise    (rise[g]),
         .fall    (fall[g])
      );
   end

endmodule

// File: tb/tb_db_multi.sv
// Testbench for db_multi: a slow-tick instance (TICK_DIV=4, STABLE=3) and a
// boundary instance (TICK_DIV=1, STABLE=1) checked against a behavioural model.
module tb_db_multi;

   localparam int CH   = 4;
   localparam int TD_A = 4;
   localparam int ST_A = 3;
   localparam int TD_B = 1;
   localparam int ST_B = 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [CH-1:0] sw_a = '0;
   logic [CH-1:0] sw_b = '0;
   logic [CH-1:0] db_a, rise_a, fall_a;
   logic [CH-1:0] db_b, rise_b, fall_b;
   logic          tick_a, tick_b;

   int cmp_count = 0;
   int err_count = 0;
   bit chk_en    = 1'b0;

   always #5 clk = ~clk;

   db_multi #(.CH(CH), .TICK_DIV(TD_A), .STABLE(ST_A), .SYNC_STAGES(2)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .sw(sw_a),
      .db(db_a), .rise(rise_a), .fall(fall_a), .tick(tick_a)
   );

   db_multi #(.CH(CH), .TICK_DIV(TD_B), .STABLE(ST_B), .SYNC_STAGES(2)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .sw(sw_b),
      .db(db_b), .rise(rise_b), .fall(fall_b), .tick(tick_b)
   );

   // Model state, index 0 = instance a, 1 = instance b
   int            n_m[2];
   logic [CH-1:0] dbm[2], risem[2], fallm[2];
   logic [CH-1:0] q0[2], q1[2];
   bit            act_m[2][CH];
   int            start_m[2][CH];

   function automatic int td_of(input int k);
      return (k == 0) ? TD_A : TD_B;
   endfunction

   function automatic int st_of(input int k);
      return (k == 0) ? ST_A : ST_B;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         n_m[k] = 0; dbm[k] = '0; risem[k] = '0; fallm[k] = '0;
         q0[k] = '0; q1[k] = '0;
         for (int i = 0; i < CH; i++) begin
            act_m[k][i] = 1'b0; start_m[k][i] = 0;
         end
      end
   endtask

   // Ticks happen on edges e with (e+1) % TD == 0; a flip occurs once a run
   // of disagreement has spanned STABLE of them.
   task automatic model_edge(input int k, input logic [CH-1:0] sw_now);
      logic [CH-1:0] s;
      int nt;
      s = q1[k];
      risem[k] = '0;
      fallm[k] = '0;
      for (int i = 0; i < CH; i++) begin
         if (s[i] == dbm[k][i]) begin
            act_m[k][i] = 1'b0;
         end else begin
            if (!act_m[k][i]) begin
               act_m[k][i]   = 1'b1;
               start_m[k][i] = n_m[k];
            end
            nt = (n_m[k] + 1) / td_of(k) - start_m[k][i] / td_of(k);
            if (nt >= st_of(k)) begin
               dbm[k][i] = s[i];
               if (s[i]) risem[k][i] = 1'b1;
               else      fallm[k][i] = 1'b1;
               act_m[k][i] = 1'b0;
            end
         end
      end
      q1[k] = q0[k];
      q0[k] = sw_now;
      n_m[k] = n_m[k] + 1;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            model_reset();
         end else begin
            model_edge(0, sw_a);
            model_edge(1, sw_b);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_count++;
      if (act !== exp) begin
         err_count++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      cmp_count++;
      if (act < lo || act > hi) begin
         err_count++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("db_a",   32'(db_a),   32'(dbm[0]));
            check("rise_a", 32'(rise_a), 32'(risem[0]));
            check("fall_a", 32'(fall_a), 32'(fallm[0]));
            check("tick_a", 32'(tick_a), 32'((n_m[0] % TD_A) == TD_A - 1));
            check("db_b",   32'(db_b),   32'(dbm[1]));
            check("rise_b", 32'(rise_b), 32'(risem[1]));
            check("fall_b", 32'(fall_b), 32'(fallm[1]));
            check("tick_b", 32'(tick_b), 32'((n_m[1] % TD_B) == TD_B - 1));
         end
      end
   end

   task automatic wait_db(input bit sel_b, input int ch, input logic val,
                          input int limit, output int n);
      logic cur;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         cur = sel_b ? db_b[ch] : db_a[ch];
      end while (cur !== val && n < limit);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) @(negedge clk);
   endtask

   int n;
   int rc;

   initial begin
      idle(3);
      chk_en = 1'b1;
      check("reset db_a",   32'(db_a),   32'h0);
      check("reset rise_a", 32'(rise_a), 32'h0);
      check("reset fall_a", 32'(fall_a), 32'h0);
      check("reset tick_a", 32'(tick_a), 32'h0);
      reset_n = 1'b1;
      idle(2);

      // Clean press on channel 0
      sw_a[0] = 1'b1;
      wait_db(1'b0, 0, 1'b1, 30, n);
      check_range("press latency", n, 11, 15);
      check("press db", 32'(db_a), 32'h1);
      check("press rise", 32'(rise_a), 32'h1);
      check("press fall", 32'(fall_a), 32'h0);
      check("model pin press", 32'(dbm[0]), 32'h1);
      @(negedge clk);
      check("press rise one cycle", 32'(rise_a), 32'h0);

      // Bounce rejection on channel 1
      rc = 0;
      for (int r = 0; r < 5; r++) begin
         sw_a[1] = 1'b1;
         for (int i = 0; i < 6; i++) begin @(negedge clk); if (rise_a[1]) rc++; end
         sw_a[1] = 1'b0;
         for (int i = 0; i < 6; i++) begin @(negedge clk); if (rise_a[1]) rc++; end
      end
      check("bounce db1", 32'(db_a[1]), 32'h0);
      check("bounce rise count", 32'(rc), 32'h0);
      sw_a[1] = 1'b1;
      for (int i = 0; i < 20; i++) begin @(negedge clk); if (rise_a[1]) rc++; end
      check("hold db1", 32'(db_a[1]), 32'h1);
      check("hold rise count", 32'(rc), 32'h1);

      // Release on channel 2
      sw_a[2] = 1'b1;
      idle(20);
      check("pre-release db", 32'(db_a), 32'h7);
      sw_a[2] = 1'b0;
      wait_db(1'b0, 2, 1'b0, 30, n);
      check_range("release latency", n, 11, 15);
      check("release fall", 32'(fall_a), 32'h4);
      check("release rise", 32'(rise_a), 32'h0);
      @(negedge clk);
      check("release fall one cycle", 32'(fall_a), 32'h0);

      // Simultaneous press on all channels
      sw_a = 4'b0000;
      idle(20);
      check("all low db", 32'(db_a), 32'h0);
      sw_a = 4'b1111;
      wait_db(1'b0, 0, 1'b1, 30, n);
      check("simul db", 32'(db_a), 32'hf);
      check("simul rise", 32'(rise_a), 32'hf);
      check("model pin simul", 32'(risem[0]), 32'hf);
      @(negedge clk);
      check("simul rise one cycle", 32'(rise_a), 32'h0);

      // Async reset while channels 1..3 are counting down
      sw_a = 4'b0001;
      idle(8);
      @(posedge clk);
      #2;
      check("pre-reset db", 32'(db_a), 32'hf);
      reset_n = 1'b0;
      #1;
      check("async db", 32'(db_a), 32'h0);
      check("async rise", 32'(rise_a), 32'h0);
      check("async fall", 32'(fall_a), 32'h0);
      check("async tick", 32'(tick_a), 32'h0);
      idle(2);
      reset_n = 1'b1;
      wait_db(1'b0, 0, 1'b1, 30, n);
      check_range("post-reset latency", n, 11, 15);
      check("post-reset rise", 32'(rise_a), 32'h1);
      check("post-reset db", 32'(db_a), 32'h1);

      // Boundary instance: db follows sw three cycles later
      check("boundary tick", 32'(tick_b), 32'h1);
      sw_b[0] = 1'b1;
      wait_db(1'b1, 0, 1'b1, 10, n);
      check("boundary rise latency", 32'(n), 32'd3);
      check("boundary rise", 32'(rise_b), 32'h1);
      @(negedge clk);
      check("boundary rise one cycle", 32'(rise_b), 32'h0);
      sw_b[0] = 1'b0;
      wait_db(1'b1, 0, 1'b0, 10, n);
      check("boundary fall latency", 32'(n), 32'd3);
      check("boundary fall", 32'(fall_b), 32'h1);
      sw_b = 4'b1010;
      idle(3);
      check("boundary multi db", 32'(db_b), 32'ha);
      check("boundary multi rise", 32'(rise_b), 32'ha);
      idle(4);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule

// File: doc/db_multi.md
Name: db_multi

Overview:
- Parametrised multi-channel switch debouncer; successor to the single-channel 3-tick debounce FSM.
- Each channel has a configurable-depth input synchroniser, a shared tick prescaler, a configurable stable-tick count, and registered rise/fall edge pulses.
- Sits between raw board switches/buttons and control logic, replacing per-switch instances with one block.

Parameters:
- CH, 4, number of independent switch channels (>=1)
- TICK_DIV, 500000, clock cycles per sample tick (>=1)
- STABLE, 3, consecutive ticks an input must differ from db before db flips (>=1)
- SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sw  in  CH  raw, asynchronous switch inputs
- db  out  CH  debounced level per channel
- rise  out  CH  one-cycle pulse when db[i] goes 0->1
- fall  out  CH  one-cycle pulse when db[i] goes 1->0
- tick  out  1  one-cycle sample strobe (debug/observability)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0): all synchroniser flops, prescaler, per-channel counters, db, rise and fall clear to 0 immediately, without waiting for clk.
- Prescaler:
  - Counter width clog2(TICK_DIV), counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 combinationally while count==TICK_DIV-1, so one cycle in every TICK_DIV.
  - If TICK_DIV=1, tick is high every cycle after reset.
- Synchroniser: sw[i] passes through SYNC_STAGES flops; s[i] is the last stage. No other logic reads sw directly.
- Per-channel state: db_r (1 bit) and cnt (clog2(STABLE+1) bits), updated at every clk edge:
  - s==db_r: cnt<=0 (bounce back cancels a pending change); db_r holds.
  - s!=db_r and tick and cnt==STABLE-1: db_r<=~db_r, cnt<=0.
  - s!=db_r and tick and cnt<STABLE-1: cnt<=cnt+1.
  - s!=db_r and no tick: hold.
- Edge pulses:
  - rise[i] and fall[i] are registered and asserted on the same edge at which db_r flips (rise when the new value is 1, fall when it is 0).
  - Each pulse lasts exactly one cycle; rise and fall are never both high for one channel.
- Latency: the first tick after a change may be partial, so db flips between SYNC_STAGES+(STABLE-1)*TICK_DIV+1 and SYNC_STAGES+STABLE*TICK_DIV+1 cycles after sw changes and then stays steady.
- Channels are fully independent; simultaneous changes on any subset are handled in parallel, sharing only the tick.
- Reset mid-count: the pending change is discarded; db=0.
  - If sw is held high through reset, db rises STABLE ticks after release and produces a rise pulse.
- db is a registered output.

Decomposition:
- Shared package db_pkg holds the clog2 constant function and default parameter values (tick period for 100 MHz board clock, STABLE=3).
- Natural sub-module db_channel: synchroniser, cnt, db_r and the edge pulse for one channel, with inputs clk, reset_n, sw_i, tick.
- db_multi holds the prescaler plus a generate loop of CH db_channel instances.

Test Plan (CH=4, TICK_DIV=4, STABLE=3, SYNC_STAGES=2):
- Clean press: sw[0] 0->1 held -> db[0] rises between cycles 11 and 15 after the change; rise[0] high exactly 1 cycle on that edge; fall[0], db[3:1] stay 0.
- Bounce rejection: sw[1] pulses high for 6 cycles then low, repeated 5 times -> db[1] never asserts; no rise pulse. Then hold high 20 cycles -> db[1]=1 with a single rise pulse.
- Release: with db[2]=1, sw[2] 1->0 held -> db[2] falls within 11..15 cycles; fall[2] is a 1-cycle pulse; no rise.
- Simultaneous channels: sw=4'b1111 in one cycle -> all db bits rise on the same edge; rise=4'b1111 for exactly one cycle.
- Async reset mid-count: sw[0]=1, assert reset_n=0 between clk edges at cycle 9 -> db, rise, fall and tick go 0 before the next edge. Release with sw still 1 -> db[0] rises 11..15 cycles later.
- Boundary: TICK_DIV=1, STABLE=1 -> tick constantly high; db follows s one cycle later (3 cycles after sw); each toggle gives one matching pulse.
